// File: rtl/mac_layer_seq.sv
// Time-multiplexed fully-connected ReLU layer with a local weight file, runtime load port and gradient update mode.
// Latency: N_IN*N_OUT cycles per pass. done_o pulses in the first idle cycle after the pass.
// Backpressure: none. start_i and wr_en_i are ignored while busy. start_i wins over wr_en_i in the same idle cycle.
module mac_layer_seq #(
    parameter int N_IN     = 4,
    parameter int N_OUT    = 8,
    parameter int X_W      = 4,
    parameter int W_W      = 8,
    parameter int G_W      = 8,
    parameter int ACC_W    = 16,
    parameter int LR_SHIFT = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic                            mode_i,
    input  logic [N_IN*X_W-1:0]             x_i,
    input  logic                            wr_en_i,
    input  logic [$clog2(N_IN*N_OUT)-1:0]   wr_addr_i,
    input  logic [W_W-1:0]                  wr_data_i,
    output logic [$clog2(N_OUT)-1:0]        grad_idx_o,
    input  logic [G_W-1:0]                  grad_i,
    input  logic [$clog2(N_OUT)-1:0]        y_sel_i,
    output logic [ACC_W-1:0]                y_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            sat_o
);

    localparam int NW   = N_IN * N_OUT;
    localparam int AW   = $clog2(NW);
    localparam int JW   = $clog2(N_OUT);
    localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int MAXW = (W_W > G_W) ? W_W : G_W;
    localparam int MW   = MAXW + X_W + 1;   // shared product width
    localparam int SW   = ACC_W + 4;        // accumulator width
    localparam int UW   = MW + 2;           // weight-update difference width

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FWD  = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;

    localparam logic signed [SW-1:0] Y_MAX = SW'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [UW-1:0] W_MAX = UW'((1 << (W_W - 1)) - 1);
    localparam logic signed [UW-1:0] W_MIN = ~W_MAX;

    logic [1:0]                 state;
    logic [IW-1:0]              i_cnt;
    logic [JW-1:0]              j_cnt;
    logic [N_IN*X_W-1:0]        x_lat;
    logic signed [W_W-1:0]      w_mem [NW];
    logic [ACC_W-1:0]           y_mem [N_OUT];
    logic signed [SW-1:0]       acc;

    logic                       accept;
    logic                       stepping;
    logic                       last_i;
    logic                       last_j;
    logic                       addr_ok;
    logic                       y_live;
    logic [AW-1:0]              widx;
    logic [X_W-1:0]             x_cur;
    logic signed [X_W:0]        x_ext;
    logic signed [W_W-1:0]      w_cur;
    logic signed [MW-1:0]       mul_a;
    logic signed [MW-1:0]       prod;
    logic signed [SW-1:0]       fwd_base;
    logic signed [SW-1:0]       fwd_sum;
    logic [ACC_W-1:0]           y_new;
    logic                       y_ovf;
    logic signed [MW-1:0]       delta;
    logic signed [UW-1:0]       w_diff;
    logic signed [W_W-1:0]      w_new;
    logic                       w_ovf;

    assign accept   = (state == S_IDLE) && start_i;
    assign stepping = (state == S_FWD) || (state == S_UPD);
    assign last_i   = (i_cnt == IW'(N_IN - 1));
    assign last_j   = (j_cnt == JW'(N_OUT - 1));
    assign addr_ok  = (32'(wr_addr_i) < NW);
    assign widx     = AW'(32'(j_cnt) * 32'(N_IN) + 32'(i_cnt));
    assign x_cur    = x_lat[32'(i_cnt) * X_W +: X_W];
    assign x_ext    = $signed({1'b0, x_cur});
    assign w_cur    = w_mem[widx];
    assign y_live   = (y_mem[j_cnt] != '0);

    assign busy_o     = stepping;
    assign grad_idx_o = (state == S_UPD) ? j_cnt : '0;
    assign y_o        = (32'(y_sel_i) < N_OUT) ? y_mem[y_sel_i] : '0;

    // Single shared multiplier: weight x input in FWD, gradient x input in UPD.
    always_comb begin
        mul_a = (state == S_UPD) ? MW'($signed(grad_i)) : MW'(w_cur);
        prod  = mul_a * MW'(x_ext);
    end

    // Forward sum with ReLU floor and positive saturation of the stored output.
    always_comb begin
        fwd_base = (i_cnt == '0) ? '0 : acc;
        fwd_sum  = fwd_base + SW'(prod);
        y_new    = fwd_sum[ACC_W-1:0];
        y_ovf    = 1'b0;
        if (fwd_sum[SW-1]) begin
            y_new = '0;
        end else if (fwd_sum > Y_MAX) begin
            y_new = Y_MAX[ACC_W-1:0];
            y_ovf = 1'b1;
        end
    end

    // Gradient step: subtract the scaled product, clamped to the signed weight range.
    always_comb begin
        delta  = prod >>> LR_SHIFT;
        w_diff = UW'(w_cur) - UW'(delta);
        w_new  = w_diff[W_W-1:0];
        w_ovf  = 1'b0;
        if (w_diff > W_MAX) begin
            w_new = W_MAX[W_W-1:0];
            w_ovf = 1'b1;
        end else if (w_diff < W_MIN) begin
            w_new = W_MIN[W_W-1:0];
            w_ovf = 1'b1;
        end
    end

    // Sequencer: accept start in IDLE, walk i fastest then j, pulse done after the final step.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            i_cnt  <= '0;
            j_cnt  <= '0;
            x_lat  <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                x_lat <= x_i;
                i_cnt <= '0;
                j_cnt <= '0;
                state <= mode_i ? S_UPD : S_FWD;
            end else if (stepping) begin
                if (last_i) begin
                    i_cnt <= '0;
                    if (last_j) begin
                        j_cnt  <= '0;
                        state  <= S_IDLE;
                        done_o <= 1'b1;
                    end else begin
                        j_cnt <= j_cnt + JW'(1);
                    end
                end else begin
                    i_cnt <= i_cnt + IW'(1);
                end
            end else if (state != S_IDLE) begin
                state <= S_IDLE;
            end
        end
    end

    // Accumulator, output registers and sticky saturation flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc   <= '0;
            sat_o <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                y_mem[k] <= '0;
            end
        end else if (accept) begin
            sat_o <= 1'b0;
        end else if (state == S_FWD) begin
            acc <= fwd_sum;
            if (last_i) begin
                y_mem[j_cnt] <= y_new;
                if (y_ovf) begin
                    sat_o <= 1'b1;
                end
            end
        end else if ((state == S_UPD) && y_live && w_ovf) begin
            sat_o <= 1'b1;
        end
    end

    // Weight file: idle-time loads, in-place updates for neurons with a live ReLU output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NW; k++) begin
                w_mem[k] <= '0;
            end
        end else if ((state == S_IDLE) && !start_i && wr_en_i && addr_ok) begin
            w_mem[wr_addr_i] <= wr_data_i;
        end else if ((state == S_UPD) && y_live) begin
            w_mem[widx] <= w_new;
        end
    end

endmodule

// File: tb/tb_mac_layer_seq.sv
// Directed bench for mac_layer_seq: default instance plus an ACC_W=12 instance sharing all inputs.
// Latency: each pass is 32 busy cycles followed by a single done pulse.
// Backpressure: none; stimulus changes on the falling clock edge, outputs sampled there too.
module tb_mac_layer_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] x_in = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [2:0]  y_sel = '0;
    logic [7:0]  grad;
    logic [7:0]  grad_tab [8];

    logic [2:0]  grad_idx, grad_idx_s;
    logic [15:0] y;
    logic [11:0] y_s;
    logic        busy, done, sat, busy_s, done_s, sat_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign grad = grad_tab[grad_idx];

    mac_layer_seq dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .x_i(x_in),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .grad_idx_o(grad_idx), .grad_i(grad), .y_sel_i(y_sel), .y_o(y),
        .busy_o(busy), .done_o(done), .sat_o(sat)
    );

    mac_layer_seq #(.ACC_W(12)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .x_i(x_in),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .grad_idx_o(grad_idx_s), .grad_i(grad), .y_sel_i(y_sel), .y_o(y_s),
        .busy_o(busy_s), .done_o(done_s), .sat_o(sat_s)
    );

    task automatic wr(input int addr, input logic [7:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'(addr); wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_all(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        for (int j = 0; j < 8; j++) begin
            wr(j*4 + 0, a); wr(j*4 + 1, b); wr(j*4 + 2, c); wr(j*4 + 3, d);
        end
    endtask

    task automatic set_grads(input logic [7:0] g0, input logic [7:0] g_rest);
        grad_tab[0] = g0;
        for (int j = 1; j < 8; j++) grad_tab[j] = g_rest;
    endtask

    // One pass: counts busy cycles, done pulses (including a late second pulse) and grad_idx sequence slips.
    // inj >= 0 pulses start+write at that busy cycle; wr_start asserts a write alongside start.
    task automatic run(input bit m, input logic [15:0] xv, input int inj, input bit wr_start,
                       output int bc, output int dc, output int gerr);
        @(negedge clk);
        start = 1'b1; mode = m; x_in = xv;
        if (wr_start) begin wr_en = 1'b1; wr_addr = 5'd31; wr_data = 8'd100; end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        bc = 0; dc = 0; gerr = 0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin dc++; break; end
            if (busy) begin
                if (grad_idx !== (m ? 3'(bc / 4) : 3'd0) || grad_idx_s !== grad_idx) gerr++;
                if (bc == inj) begin
                    start = 1'b1; mode = 1'b1; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 8'd100;
                end
                bc++;
            end
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0; mode = m;
        end
        @(negedge clk);
        if (done) dc++;
    endtask

    task automatic get_y(input int jj, output logic [15:0] v, output logic [11:0] vs);
        y_sel = 3'(jj);
        #1;
        v = y; vs = y_s;
    endtask

    task automatic test_reset;
        logic [15:0] v; logic [11:0] vs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, sat} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/done/sat %b want 000", {busy, done, sat}); end
        checks++; if ({busy_s, done_s, sat_s} !== 3'b000) begin errors++; $display("FAIL reset_flags_s: %b want 000", {busy_s, done_s, sat_s}); end
        checks++; if (grad_idx !== 3'd0) begin errors++; $display("FAIL reset_grad_idx: got %0d want 0", grad_idx); end
        for (int j = 0; j < 8; j++) begin
            get_y(j, v, vs);
            checks++; if (v !== 16'd0) begin errors++; $display("FAIL reset_y%0d: got %0d want 0", j, v); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fwd_basic;
        int bc, dc, ge; logic [15:0] v; logic [11:0] vs;
        load_all(8'd1, 8'd2, 8'd3, 8'd4);
        run(1'b0, 16'h1111, -1, 1'b0, bc, dc, ge);
        checks++; if (bc !== 32) begin errors++; $display("FAIL fwd_busy_cycles: got %0d want 32", bc); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL fwd_done_pulses: got %0d want 1", dc); end
        checks++; if (ge !== 0) begin errors++; $display("FAIL fwd_grad_idx_zero: %0d bad cycles want 0", ge); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL fwd_sat: got %0b want 0", sat); end
        for (int j = 0; j < 8; j++) begin
            get_y(j, v, vs);
            checks++; if (v !== 16'd10) begin errors++; $display("FAIL fwd_y%0d: got %0d want 10", j, v); end
        end
    endtask

    task automatic test_relu;
        int bc, dc, ge; logic [15:0] v; logic [11:0] vs;
        load_all(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run(1'b0, 16'hFFFF, -1, 1'b0, bc, dc, ge);
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL relu_sat: got %0b want 0", sat); end
        for (int j = 0; j < 8; j++) begin
            get_y(j, v, vs);
            checks++; if (v !== 16'd0) begin errors++; $display("FAIL relu_y%0d: got %0d want 0", j, v); end
        end
    endtask

    task automatic test_saturation;
        int bc, dc, ge; logic [15:0] v; logic [11:0] vs;
        load_all(8'd127, 8'd127, 8'd127, 8'd127);
        run(1'b0, 16'hFFFF, -1, 1'b0, bc, dc, ge);
        get_y(3, v, vs);
        checks++; if (v !== 16'd7620) begin errors++; $display("FAIL sat_wide_y: got %0d want 7620", v); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_wide_flag: got %0b want 0", sat); end
        checks++; if (vs !== 12'd2047) begin errors++; $display("FAIL sat_narrow_y: got %0d want 2047", vs); end
        checks++; if (sat_s !== 1'b1) begin errors++; $display("FAIL sat_narrow_flag: got %0b want 1", sat_s); end
        load_all(8'd1, 8'd2, 8'd3, 8'd4);
        run(1'b0, 16'h1111, -1, 1'b0, bc, dc, ge);
        checks++; if (sat_s !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0b want 0", sat_s); end
        get_y(3, v, vs);
        checks++; if (vs !== 12'd10) begin errors++; $display("FAIL sat_clear_y: got %0d want 10", vs); end
    endtask

    task automatic test_update;
        int bc, dc, ge; logic [15:0] v; logic [11:0] vs;
        // y[] is 10 everywhere from the previous pass.
        wr(0, 8'd10);
        set_grads(8'd16, 8'd0);
        run(1'b1, 16'h1114, -1, 1'b0, bc, dc, ge);
        checks++; if (bc !== 32 || dc !== 1) begin errors++; $display("FAIL upd_timing: busy %0d done %0d want 32/1", bc, dc); end
        run(1'b0, 16'h0001, -1, 1'b0, bc, dc, ge);
        get_y(0, v, vs);
        checks++; if (v !== 16'd6) begin errors++; $display("FAIL upd_w00: got %0d want 6", v); end
        get_y(1, v, vs);
        checks++; if (v !== 16'd1) begin errors++; $display("FAIL upd_w10_zero_grad: got %0d want 1", v); end
        // Dead neuron: y[0] = 0 must freeze its weights.
        wr(0, 8'hFF);
        run(1'b0, 16'h0001, -1, 1'b0, bc, dc, ge);
        get_y(0, v, vs);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL upd_dead_setup: got %0d want 0", v); end
        wr(0, 8'd10);
        run(1'b1, 16'h1114, -1, 1'b0, bc, dc, ge);
        run(1'b0, 16'h0001, -1, 1'b0, bc, dc, ge);
        get_y(0, v, vs);
        checks++; if (v !== 16'd10) begin errors++; $display("FAIL upd_dead_frozen: got %0d want 10", v); end
    endtask

    task automatic test_upd_clamp;
        int bc, dc, ge; logic [15:0] v; logic [11:0] vs;
        load_all(8'd1, 8'd1, 8'd1, 8'd1);
        run(1'b0, 16'hFFFF, -1, 1'b0, bc, dc, ge);   // y = 60 everywhere
        load_all(8'h80, 8'h80, 8'h80, 8'h80);
        set_grads(8'h80, 8'h80);
        run(1'b1, 16'hFFFF, -1, 1'b0, bc, dc, ge);   // -128 -> -8
        checks++; if (ge !== 0) begin errors++; $display("FAIL clamp_grad_idx_seq: %0d bad cycles want 0", ge); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL clamp_pass1_sat: got %0b want 0", sat); end
        run(1'b1, 16'hFFFF, -1, 1'b0, bc, dc, ge);   // -8 -> 112
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL clamp_pass2_sat: got %0b want 0", sat); end
        run(1'b1, 16'hFFFF, -1, 1'b0, bc, dc, ge);   // 112 -> 232, clamps to 127
        checks++; if (sat !== 1'b1) begin errors++; $display("FAIL clamp_pass3_sat: got %0b want 1", sat); end
        run(1'b0, 16'h0001, -1, 1'b0, bc, dc, ge);
        get_y(0, v, vs);
        checks++; if (v !== 16'd127) begin errors++; $display("FAIL clamp_w0: got %0d want 127", v); end
        get_y(7, v, vs);
        checks++; if (v !== 16'd127) begin errors++; $display("FAIL clamp_w7: got %0d want 127", v); end
    endtask

    task automatic test_busy_ignore;
        int bc, dc, ge; logic [15:0] v; logic [11:0] vs;
        load_all(8'd1, 8'd2, 8'd3, 8'd4);
        run(1'b0, 16'h1111, 5, 1'b1, bc, dc, ge);
        checks++; if (bc !== 32) begin errors++; $display("FAIL ignore_busy_cycles: got %0d want 32", bc); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL ignore_done_pulses: got %0d want 1", dc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_restart: busy %0b want 0", busy); end
        get_y(0, v, vs);
        checks++; if (v !== 16'd10) begin errors++; $display("FAIL ignore_y0: got %0d want 10", v); end
        get_y(7, v, vs);
        checks++; if (v !== 16'd10) begin errors++; $display("FAIL ignore_y7_write_dropped: got %0d want 10", v); end
    endtask

    task automatic test_reset_mid;
        int bc, dc, ge, dseen; logic [15:0] v; logic [11:0] vs;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; x_in = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_running: busy %0b want 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        for (int j = 0; j < 8; j++) begin
            get_y(j, v, vs);
            checks++; if (v !== 16'd0) begin errors++; $display("FAIL midrst_y%0d: got %0d want 0", j, v); end
        end
        dseen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) dseen++;
        end
        checks++; if (dseen !== 0) begin errors++; $display("FAIL midrst_done: %0d pulses want 0", dseen); end
        rst = 1'b0;
        run(1'b0, 16'h1111, -1, 1'b0, bc, dc, ge);
        checks++; if (dc !== 1) begin errors++; $display("FAIL midrst_rerun_done: got %0d want 1", dc); end
        get_y(0, v, vs);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL midrst_weights_cleared: got %0d want 0", v); end
    endtask

    initial begin
        set_grads(8'd0, 8'd0);
        test_reset();
        test_fwd_basic();
        test_relu();
        test_saturation();
        test_update();
        test_upd_clamp();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
